// File: rtl/sram_word_loader.sv
// Write-side SRAM initiator: packs a byte stream little-endian into 32-bit words
// and writes them to consecutive addresses over the req/ack interface.
module sram_word_loader #(
    parameter int unsigned depth     = 196,
    parameter int unsigned addr_bit  = 12,
    parameter int unsigned base_addr = 0
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                start,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    output logic                req,
    output logic                r0w1,
    output logic [addr_bit-1:0] addr,
    output logic [31:0]         wdata,
    input  logic                ack,
    output logic                busy,
    output logic                done,
    output logic [addr_bit-1:0] word_count
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    localparam logic [addr_bit-1:0] BASE = addr_bit'(base_addr);
    localparam logic [addr_bit-1:0] LAST = addr_bit'(depth - 1);

    state_t              state_q, state_d;
    logic [addr_bit-1:0] addr_q, addr_d;
    logic [addr_bit-1:0] wc_q, wc_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [1:0]          lane_q, lane_d;
    logic                req_q, req_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wc_q    <= '0;
            wdata_q <= '0;
            lane_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            wdata_q <= wdata_d;
            lane_q  <= lane_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        wdata_d = wdata_q;
        lane_d  = lane_q;
        req_d   = req_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    addr_d  = BASE;
                    lane_d  = '0;
                    wc_d    = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (byte_valid) begin
                    wdata_d[{lane_q, 3'b000} +: 8] = byte_data;
                    if (lane_q == 2'd3) begin
                        lane_d  = '0;
                        req_d   = 1'b1;
                        state_d = WRITE;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                // req/addr/wdata stay frozen until the SRAM acknowledges
                if (ack) begin
                    req_d = 1'b0;
                    wc_d  = wc_q + 1'b1;
                    if (wc_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_ready = (state_q == FILL);
    assign busy       = (state_q == FILL) || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign req        = req_q;
    assign r0w1       = req_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_sram_word_loader.sv
// Directed bench for sram_word_loader: six-word load across the address wrap,
// stalls, ignored start/ack, multi-cycle ack, reload and reset mid-write.
module tb_sram_word_loader;

    localparam int DEPTH = 6;
    localparam int AW    = 12;
    localparam int BASE  = 4093;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          req;
    logic          r0w1;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          ack;
    logic          busy;
    logic          done;
    logic [AW-1:0] word_count;

    int n_checks = 0;
    int n_err    = 0;

    sram_word_loader #(.depth(DEPTH), .addr_bit(AW), .base_addr(BASE)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .req(req), .r0w1(r0w1),
        .addr(addr), .wdata(wdata), .ack(ack), .busy(busy), .done(done),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Hand-computed expectations: word 0 from bytes 11,22,33,44; word i>0 from bytes 4i..4i+3.
    logic [31:0]   exp_word [DEPTH] = '{32'h44332211, 32'h07060504, 32'h0B0A0908,
                                        32'h0F0E0D0C, 32'h13121110, 32'h17161514};
    logic [AW-1:0] exp_addr [DEPTH] = '{12'd4093, 12'd4094, 12'd4095, 12'd0, 12'd1, 12'd2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ready", byte_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_addr", addr, BASE);
        chk("start_wc", word_count, 0);
    endtask

    // Feed word index i; optional one-cycle valid gap before lane 2 and start pulse with lane 1.
    task automatic feed_word(input int i, input bit gap, input bit pulse_start);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            if (gap && k == 2) begin
                byte_valid = 1'b0;
                byte_data  = 8'hEE;
                @(negedge clk);
                chk("gap_ready", byte_ready, 1);
                chk("gap_req", req, 0);
            end
            if (i == 0) b = 8'h11 * 8'(k + 1);
            else        b = 8'(4 * i + k);
            byte_valid = 1'b1;
            byte_data  = b;
            start      = pulse_start && (k == 1);
            @(negedge clk);
            start = 1'b0;
        end
        byte_valid = 1'b0;
        chk("fill_req", req, 1);
        chk("fill_r0w1", r0w1, 1);
        chk("fill_ready", byte_ready, 0);
        chk("fill_addr", addr, exp_addr[i]);
        chk("fill_wdata", wdata, exp_word[i]);
    endtask

    // Hold ack low for lat cycles (checking stability), then raise it for hold cycles.
    task automatic do_ack(input int i, input int lat, input int hold);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            chk("stall_req", req, 1);
            chk("stall_addr", addr, exp_addr[i]);
            chk("stall_wdata", wdata, exp_word[i]);
        end
        ack = 1'b1;
        for (int h = 0; h < hold; h++) @(negedge clk);
        ack = 1'b0;
        chk("ack_req", req, 0);
        chk("ack_wc", word_count, i + 1);
    endtask

    initial begin
        rst_b = 1'b0; start = 1'b1; byte_valid = 1'b1; byte_data = 8'hA5; ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_r0w1", r0w1, 0);
        chk("rst_ready", byte_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wc", word_count, 0);
        start = 1'b0; byte_valid = 1'b0; ack = 1'b0;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", byte_ready, 0);
        chk("idle_busy", busy, 0);

        start_load();
        feed_word(0, 0, 0); do_ack(0, 0, 1);
        feed_word(1, 1, 0); do_ack(1, 3, 1);
        feed_word(2, 0, 1); do_ack(2, 1, 3);
        chk("ack3_wc", word_count, 3);
        // ack while filling must be ignored
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("fill_ack_wc", word_count, 3);
        chk("fill_ack_ready", byte_ready, 1);
        feed_word(3, 1, 0); do_ack(3, 5, 1);
        feed_word(4, 0, 0); do_ack(4, 2, 1);
        feed_word(5, 0, 0); do_ack(5, 0, 1);
        chk("done_done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_wc", word_count, DEPTH);
        chk("done_addr", addr, 2);
        chk("done_wdata", wdata, 32'h17161514);
        @(negedge clk);
        chk("done_hold", done, 1);

        start_load();
        feed_word(0, 0, 0);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("midrst_req", req, 0);
        chk("midrst_r0w1", r0w1, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", addr, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        start_load();
        feed_word(0, 0, 0); do_ack(0, 1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_word_loader.md
# sram_word_loader

Write-side initiator for the accelerator's req/ack SRAM interface. It accepts a byte stream (image pixels, W1/W2 weights or biases), packs four bytes little-endian into 32-bit words and writes them to consecutive SRAM addresses with `r0w1`=1. It replaces hierarchical backdoor preloading: one instance per SRAM bank, run between images while the inference core is idle.

## Interface
Parameters:
- `depth`, 196: number of 32-bit words written per load (196 = one 784-byte image).
- `addr_bit`, 12: SRAM address width.
- `base_addr`, 0: first SRAM word address written.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a load; sampled in IDLE or DONE only.
- `byte_valid`  in  1  `byte_data` valid.
- `byte_data`  in  8  next byte, stream order = memory byte order.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `req`  out  1  SRAM request.
- `r0w1`  out  1  1 whenever `req`=1, else 0.
- `addr`  out  addr_bit  SRAM word address.
- `wdata`  out  32  SRAM write data.
- `ack`  in  1  SRAM acknowledge.
- `busy`  out  1  load in progress (FILL or WRITE).
- `done`  out  1  load complete; level, held until next `start`.
- `word_count`  out  addr_bit  words written and acknowledged in current load.

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE: `start`=1 -> `addr`<=`base_addr`, lane<=0, `word_count`<=0, go FILL.
- FILL: `byte_ready`=1. On `byte_valid`&`byte_ready`: `wdata[8*lane+7:8*lane]`<=`byte_data`, lane++. Accepting the byte at lane 3 -> lane<=0, `req`<=1, go WRITE. `byte_valid`=0 stalls without side effects.
- WRITE: `byte_ready`=0. `req`, `r0w1`, `addr`, `wdata` held stable until `ack` sampled 1. On that edge: `req`<=0, `word_count`++. If `word_count` was `depth`-1 -> go DONE; else `addr`++, go FILL.
- DONE: `done`=1, `busy`=0, `addr`/`wdata` hold last values. `start`=1 -> same actions as in IDLE, `done`<=0.
- `start` in FILL or WRITE is ignored (no restart, no error).
- `ack` outside WRITE is ignored.
- `busy` = state is FILL or WRITE.
- Byte order: stream byte 4n+k lands in word `base_addr`+n, bits [8k+7:8k].
- `addr` increments with natural wrap at 2^addr_bit; no range check against the SRAM size.

## Timing
- Reset (async assert): state IDLE; `req`, `r0w1`, `byte_ready`, `busy`, `done` = 0; `addr`, `wdata`, `word_count`, lane = 0. Reset mid-load abandons the load; a pending `req` drops immediately, without waiting for `ack`.
- `req` is registered. It rises on the edge that accepts lane-3 byte and falls on the edge where `ack`=1 is sampled. At least one `req`-low cycle separates consecutive writes because FILL needs at least 4 cycles.
- Any `ack` latency ≥ 1 cycle after `req` rises is tolerated. An `ack` held high for multiple cycles counts once (counted only in WRITE).
- `byte_ready` is combinational from state (FILL only). It does not depend on `byte_valid`.
- Best-case per-word cost with continuous `byte_valid` and `ack` one cycle after `req`: 4 FILL cycles + 2 WRITE cycles = 6 cycles. Full image: 196×6 = 1176 cycles from `start` to `done`.
- `done` rises on the edge following the last `ack`. `word_count`=`depth` at that point.

## Test plan
- Reset/idle: hold `rst_b`=0, toggle `start`/`byte_valid` -> all outputs 0. Release reset; with no `start`, `byte_ready` stays 0.
- Single word, `depth`=1, `base_addr`=11: feed 0x11,0x22,0x33,0x44 -> one write with `addr`=11, `wdata`=0x44332211, `r0w1`=1. After `ack`, `done`=1 and `word_count`=1.
- Full image against `dummy_sram` (depth 196): stream 784 bytes 0..255 repeating -> `mem_cell[i]` byte k = (4i+k) mod 256 for all i. `done` after 196 acks. `start` in DONE reloads from `addr` 0.
- Backpressure/stall: gap `byte_valid` randomly and delay `ack` 1-5 cycles -> `req`/`addr`/`wdata` stay stable while `ack`=0. Exactly one write per `ack`. Memory contents are identical to the unstalled run.
- Ignored events: pulse `start` mid-FILL and `ack` during FILL -> no state change, no extra `word_count` increment. A 3-cycle `ack` pulse counts as one word.
- Reset mid-WRITE: assert `rst_b`=0 while `req`=1 -> `req` low immediately. A subsequent `start` rewrites from `base_addr` with correct data.
